// File: rtl/fila_pkg.sv
// fila_pkg: shared constants and the FSM state type for the FILA arbiter.
//   DATA_W  - producer/consumer byte width
//   DEPTH   - default queue capacity in entries
//   CLK_DIV - default clock1M cycles per 10 kHz service slot
//   LEN_W   - width of the queue occupancy bus
//   state_e - arbiter FSM states
package fila_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned CLK_DIV = 100;
  localparam int unsigned LEN_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    ENQ,
    DEQ,
    WAIT_DATA,
    DELIVER
  } state_e;

endpackage

// File: rtl/fila_tick_gen.sv
// fila_tick_gen: slot divider. Counts 0..CLK_DIV-1 and raises tick for the
// single cycle in which the count equals CLK_DIV-1, then wraps to 0.
//   clock1M - system clock
//   reset   - synchronous, active-high; clears the count to 0
//   tick    - one-cycle slot strobe
module fila_tick_gen
  import fila_pkg::*;
#(
  parameter int unsigned CLK_DIV = fila_pkg::CLK_DIV
) (
  input  logic clock1M,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock1M) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fila_arbiter.sv
// fila_arbiter: shares one external queue between two producers and one
// consumer, issuing at most one queue operation per 10 kHz slot.
//   clock1M, reset          - clock and synchronous active-high reset
//   p0_req/p1_req, p*_data  - producer enqueue requests and bytes
//   p0_ack/p1_ack           - one-cycle "byte enqueued" acknowledges
//   c_req, c_data, c_valid  - consumer dequeue request, byte, qualifier
//   q_data_in, q_enqueue,
//   q_dequeue               - command bus to the queue
//   q_data_out, q_len       - queue read data and occupancy
//   full, empty, busy       - q_len==DEPTH, q_len==0, FSM not in IDLE
module fila_arbiter
  import fila_pkg::*;
#(
  parameter int unsigned CLK_DIV = fila_pkg::CLK_DIV,
  parameter int unsigned DEPTH   = fila_pkg::DEPTH
) (
  input  logic              clock1M,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic [DATA_W-1:0] p0_data,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p0_ack,
  output logic              p1_ack,
  input  logic              c_req,
  output logic [DATA_W-1:0] c_data,
  output logic              c_valid,
  output logic [DATA_W-1:0] q_data_in,
  output logic              q_enqueue,
  output logic              q_dequeue,
  input  logic [DATA_W-1:0] q_data_out,
  input  logic [LEN_W-1:0]  q_len,
  output logic              full,
  output logic              empty,
  output logic              busy
);

  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

  logic tick;

  fila_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock1M (clock1M),
    .reset   (reset),
    .tick    (tick)
  );

  state_e            state_q, state_d;
  logic              rr_q, rr_d;           // 1: p1 favoured on contention
  logic              fav_deq_q, fav_deq_d; // 1: dequeue favoured on contention
  logic              sel_q, sel_d;         // producer granted for ENQ (1 = p1)
  logic [DATA_W-1:0] c_data_q, c_data_d;
  logic              c_valid_q, c_valid_d;

  logic enq_ok, deq_ok, pick_p1;

  assign full    = (q_len == DEPTH_LEN);
  assign empty   = (q_len == '0);
  assign busy    = (state_q != IDLE);
  assign c_data  = c_data_q;
  assign c_valid = c_valid_q;

  assign enq_ok  = (p0_req | p1_req) & ~full;
  assign deq_ok  = c_req & ~empty;
  assign pick_p1 = p1_req & (~p0_req | rr_q);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    fav_deq_d = fav_deq_q;
    sel_d     = sel_q;
    c_data_d  = c_data_q;
    c_valid_d = 1'b0;
    q_enqueue = 1'b0;
    q_dequeue = 1'b0;
    q_data_in = '0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          // The op toggle records the kind of the last issued operation so
          // that, under contention, the opposite kind wins.
          if (enq_ok && (!deq_ok || !fav_deq_q)) begin
            state_d   = ENQ;
            sel_d     = pick_p1;
            rr_d      = ~pick_p1;
            fav_deq_d = 1'b1;
          end else if (deq_ok) begin
            state_d   = DEQ;
            fav_deq_d = 1'b0;
          end
        end
      end
      ENQ: begin
        q_enqueue = 1'b1;
        q_data_in = sel_q ? p1_data : p0_data;
        p0_ack    = ~sel_q;
        p1_ack    = sel_q;
        state_d   = IDLE;
      end
      DEQ: begin
        q_dequeue = 1'b1;
        state_d   = WAIT_DATA;
      end
      WAIT_DATA: begin
        state_d = DELIVER;
      end
      DELIVER: begin
        c_data_d  = q_data_out;
        c_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock1M) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      fav_deq_q <= 1'b0;
      sel_q     <= 1'b0;
      c_data_q  <= '0;
      c_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      fav_deq_q <= fav_deq_d;
      sel_q     <= sel_d;
      c_data_q  <= c_data_d;
      c_valid_q <= c_valid_d;
    end
  end

endmodule
